// File: rtl/stage_d_writeback.sv
// stage_d_writeback: data write-back stage of the bfcpu2 pipeline.
//   Commits +/-/, results to DRAM at the operand address. Queues '.' bytes into a
//   console FIFO that is drained by a valid/ready handshake. Forwards the op and
//   the updated cell value downstream for loop resolution.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   operation_in, addr_in,     one-hot op, operand address and operand from fetch
//   a_in
//   ack                        accept back to fetch (combinational)
//   operation, a, ack_in       op and updated value to next stage; next stage ready
//   dwe, dwa, dwd              DRAM write strobe (1-cycle pulse), address, data
//   cout, cout_valid,          console FIFO head and handshake
//   cout_ready
//   out_level                  console FIFO occupancy
module stage_d_writeback #(
   parameter int unsigned A_WIDTH   = 12,
   parameter int unsigned D_WIDTH   = 8,
   parameter int unsigned OUT_DEPTH = 4,
   localparam int unsigned OPCODE_MSB = 7,
   localparam int unsigned LW         = $clog2(OUT_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [OPCODE_MSB:0]   operation_in,
   output logic                  ack,
   input  logic [A_WIDTH-1:0]    addr_in,
   input  logic [D_WIDTH-1:0]    a_in,
   output logic [OPCODE_MSB:0]   operation,
   input  logic                  ack_in,
   output logic [D_WIDTH-1:0]    a,
   output logic                  dwe,
   output logic [A_WIDTH-1:0]    dwa,
   output logic [D_WIDTH-1:0]    dwd,
   output logic [7:0]            cout,
   output logic                  cout_valid,
   input  logic                  cout_ready,
   output logic [LW-1:0]         out_level
);

   // One-hot opcode bit positions.
   localparam int unsigned OP_INC       = 0;
   localparam int unsigned OP_DEC       = 1;
   localparam int unsigned OP_RIGHT     = 2;
   localparam int unsigned OP_LEFT      = 3;
   localparam int unsigned OP_OUT       = 4;
   localparam int unsigned OP_IN        = 5;
   localparam int unsigned OP_LOOPBEGIN = 6;
   localparam int unsigned OP_LOOPEND   = 7;

   localparam int unsigned PW = $clog2(OUT_DEPTH);

   logic [7:0]         mem [OUT_DEPTH];
   logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
   logic [LW-1:0]      count_q, count_d;
   logic [D_WIDTH-1:0] result;
   logic [7:0]         out_byte;
   logic               is_write, is_out, out_stall, accept, push, pop;

   // Console bytes are always 8 bits regardless of the cell width.
   if (D_WIDTH >= 8) begin : g_trunc
      assign out_byte = a_in[7:0];
   end else begin : g_zext
      assign out_byte = {{(8 - D_WIDTH){1'b0}}, a_in};
   end

   always_comb begin
      result = a_in;
      if (operation_in[OP_INC]) begin
         result = a_in + D_WIDTH'(1);
      end else if (operation_in[OP_DEC]) begin
         result = a_in - D_WIDTH'(1);
      end
   end

   assign is_write   = operation_in[OP_INC] | operation_in[OP_DEC] | operation_in[OP_IN];
   assign is_out     = operation_in[OP_OUT];
   // A full FIFO stalls even if it pops this cycle; no same-cycle bypass.
   assign out_stall  = is_out && (count_q == LW'(OUT_DEPTH));
   assign ack        = ack_in && !out_stall;
   assign accept     = ack;
   assign push       = accept && is_out;
   assign cout_valid = (count_q != '0);
   assign pop        = cout_valid && cout_ready;
   assign cout       = mem[rd_ptr_q];
   assign out_level  = count_q;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + LW'(1);
         2'b01:   count_d = count_q - LW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         operation <= '0;
         a         <= '0;
         dwe       <= 1'b0;
         dwa       <= '0;
         dwd       <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         if (accept) begin
            operation <= operation_in;
            a         <= result;
            dwe       <= is_write;
            dwa       <= addr_in;
            dwd       <= result;
         end else if (ack_in) begin
            // Stalled on a full FIFO: send a bubble, the op is retried.
            operation <= '0;
            a         <= '0;
            dwe       <= 1'b0;
         end else begin
            dwe <= 1'b0;
         end
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   // Storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= out_byte;
   end

   // Keeps the unused opcode positions documented without lint noise.
   logic unused_ops;
   assign unused_ops = operation_in[OP_RIGHT] ^ operation_in[OP_LEFT] ^
                       operation_in[OP_LOOPBEGIN] ^ operation_in[OP_LOOPEND];

endmodule

// File: tb/tb_stage_d_writeback.sv
module tb_stage_d_writeback;

   localparam logic [7:0] OP_NOP     = 8'h00;
   localparam logic [7:0] OP_INC     = 8'h01;
   localparam logic [7:0] OP_DEC     = 8'h02;
   localparam logic [7:0] OP_OUT     = 8'h10;
   localparam logic [7:0] OP_IN      = 8'h20;
   localparam logic [7:0] OP_LOOPEND = 8'h80;

   logic        clk, reset;
   logic [7:0]  operation_in, operation;
   logic        ack, ack_in;
   logic [11:0] addr_in, dwa;
   logic [7:0]  a_in, a, dwd, cout;
   logic        dwe, cout_valid, cout_ready;
   logic [2:0]  out_level;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q [$];

   stage_d_writeback dut (
      .clk(clk), .reset(reset), .operation_in(operation_in), .ack(ack),
      .addr_in(addr_in), .a_in(a_in), .operation(operation), .ack_in(ack_in),
      .a(a), .dwe(dwe), .dwa(dwa), .dwd(dwd), .cout(cout), .cout_valid(cout_valid),
      .cout_ready(cout_ready), .out_level(out_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Settle inputs, score any push/pop at the coming edge, then step past the edge.
   task automatic tick();
      #1;
      if (ack && operation_in == OP_OUT) exp_q.push_back(a_in);
      if (cout_valid && cout_ready) begin
         if (exp_q.size() == 0) chk("pop_unexpected", 32'(cout), 32'hxx);
         else chk("cout_order", 32'(cout), 32'(exp_q.pop_front()));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] op, input logic [7:0] d, input logic [11:0] ad);
      operation_in = op;
      a_in         = d;
      addr_in      = ad;
   endtask

   initial begin
      reset = 1'b0;
      ack_in = 1'b1;
      cout_ready = 1'b0;
      drive(OP_NOP, 8'h00, 12'h000);
      #2;
      chk("rst_operation", 32'(operation), 32'h0);
      chk("rst_dwe", 32'(dwe), 32'h0);
      chk("rst_valid", 32'(cout_valid), 32'h0);
      chk("rst_level", 32'(out_level), 32'h0);
      #10 reset = 1'b1;

      // 1: INC wraps FF -> 00
      drive(OP_INC, 8'hFF, 12'h005);
      #1 chk("t1_ack", 32'(ack), 32'h1);
      tick();
      chk("t1_dwe", 32'(dwe), 32'h1);
      chk("t1_dwa", 32'(dwa), 32'h005);
      chk("t1_dwd", 32'(dwd), 32'h00);
      chk("t1_a", 32'(a), 32'h00);
      chk("t1_op", 32'(operation), 32'(OP_INC));
      drive(OP_NOP, 8'h00, 12'h000);
      tick();
      chk("t1_dwe_low", 32'(dwe), 32'h0);

      // 2: DEC wrap, IN passthrough, LOOPEND no write
      drive(OP_DEC, 8'h00, 12'h010);
      tick();
      chk("t2_dec_dwd", 32'(dwd), 32'hFF);
      chk("t2_dec_a", 32'(a), 32'hFF);
      drive(OP_IN, 8'h41, 12'h011);
      tick();
      chk("t2_in_dwd", 32'(dwd), 32'h41);
      chk("t2_in_dwe", 32'(dwe), 32'h1);
      drive(OP_LOOPEND, 8'h07, 12'h012);
      tick();
      chk("t2_le_dwe", 32'(dwe), 32'h0);
      chk("t2_le_a", 32'(a), 32'h07);

      // 3: fill FIFO, 5th OUT stalls
      for (int i = 0; i < 4; i++) begin
         drive(OP_OUT, 8'(8'h41 + i), 12'h020);
         tick();
      end
      chk("t3_level4", 32'(out_level), 32'h4);
      drive(OP_OUT, 8'h45, 12'h020);
      #1 chk("t3_stall_ack", 32'(ack), 32'h0);
      tick();
      chk("t3_bubble_op", 32'(operation), 32'h0);
      chk("t3_bubble_a", 32'(a), 32'h0);
      chk("t3_hold_head", 32'(cout), 32'h41);
      cout_ready = 1'b1;
      tick();                                   // pops A; full blocked E at this edge
      chk("t3_level3", 32'(out_level), 32'h3);
      chk("t3_ack_again", 32'(ack), 32'h1);
      tick();                                   // E accepted, B popped
      chk("t3_e_op", 32'(operation), 32'(OP_OUT));
      chk("t3_level3b", 32'(out_level), 32'h3);
      drive(OP_NOP, 8'h00, 12'h000);
      tick();                                   // pops C
      chk("t4_level2", 32'(out_level), 32'h2);

      // 4: push and pop together at level 2
      drive(OP_OUT, 8'h46, 12'h020);
      tick();                                   // pops D, pushes F
      chk("t4_level_same", 32'(out_level), 32'h2);
      chk("t4_head", 32'(cout), 32'h45);
      cout_ready = 1'b0;

      // 5: back-pressure from next stage
      drive(OP_LOOPEND, 8'h07, 12'h003);
      tick();
      drive(OP_INC, 8'h10, 12'h0AA);
      ack_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t5_ack", 32'(ack), 32'h0);
         tick();
         chk("t5_no_dwe", 32'(dwe), 32'h0);
         chk("t5_op_hold", 32'(operation), 32'(OP_LOOPEND));
         chk("t5_a_hold", 32'(a), 32'h07);
         chk("t5_dwa_hold", 32'(dwa), 32'h003);
      end
      ack_in = 1'b1;
      tick();
      chk("t5_dwe", 32'(dwe), 32'h1);
      chk("t5_dwd", 32'(dwd), 32'h11);
      drive(OP_NOP, 8'h00, 12'h000);
      tick();
      chk("t5_once", 32'(dwe), 32'h0);

      // 6: async reset mid-drain
      drive(OP_OUT, 8'h47, 12'h020);
      tick();
      drive(OP_INC, 8'h20, 12'h030);
      tick();
      chk("t6_pre_level", 32'(out_level), 32'h3);
      chk("t6_pre_dwe", 32'(dwe), 32'h1);
      cout_ready = 1'b1;
      #1 reset = 1'b0;
      #1;
      chk("t6_dwe", 32'(dwe), 32'h0);
      chk("t6_op", 32'(operation), 32'h0);
      chk("t6_a", 32'(a), 32'h0);
      chk("t6_dwa", 32'(dwa), 32'h0);
      chk("t6_dwd", 32'(dwd), 32'h0);
      chk("t6_valid", 32'(cout_valid), 32'h0);
      chk("t6_level", 32'(out_level), 32'h0);
      exp_q.delete();
      drive(OP_NOP, 8'h00, 12'h000);
      #1 reset = 1'b1;
      tick();                                   // pop while empty is ignored
      chk("t6_empty_pop", 32'(out_level), 32'h0);
      drive(OP_INC, 8'hFF, 12'h005);
      tick();
      chk("t6_dwe_after", 32'(dwe), 32'h1);
      chk("t6_dwa_after", 32'(dwa), 32'h005);
      chk("t6_dwd_after", 32'(dwd), 32'h00);
      chk("t6_op_after", 32'(operation), 32'(OP_INC));
      drive(OP_NOP, 8'h00, 12'h000);
      tick();
      chk("t6_dwe_low", 32'(dwe), 32'h0);
      chk("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
